// File: rtl/debounce_scheduler.sv
// -----------------------------------------------------------------------------
// debounce_scheduler
//   Debounces CHANNELS noisy inputs with a single shared settle timer. A channel
//   whose (optionally synchronised) input differs from its debounced level
//   requests the timer; a round-robin arbiter hands the timer to one channel at
//   a time and a three-state FSM (IDLE/TIMING/COMMIT) clears, counts and commits.
//
//   Optional feature: define SYNC2_EN to insert a 2-flop synchroniser on every
//   noisy bit (adds 2 cycles to every latency).
//
// Ports
//   clk        in   1                  clock, all state on posedge
//   reset_n    in   1                  asynchronous active-low reset
//   noisy      in   CHANNELS           raw inputs, one bit per channel
//   debounced  out  CHANNELS           clean levels (registered)
//   changed    out  CHANNELS           one-cycle pulse when debounced[i] toggles
//   busy       out  1                  high while the FSM is not IDLE
//   grant_idx  out  $clog2(CHANNELS)   channel owning the timer, valid while busy
// -----------------------------------------------------------------------------
module debounce_scheduler #(
   parameter int unsigned CHANNELS      = 4,
   parameter int unsigned SETTLE_CYCLES = 500000
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic [CHANNELS-1:0]         noisy,
   output logic [CHANNELS-1:0]         debounced,
   output logic [CHANNELS-1:0]         changed,
   output logic                        busy,
   output logic [$clog2(CHANNELS)-1:0] grant_idx
);

   localparam int unsigned IDX_W = $clog2(CHANNELS);
   localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_TIMING = 2'd1,
      ST_COMMIT = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    timer_q, timer_d;
   logic [IDX_W-1:0]    grant_q, grant_d;
   logic [IDX_W-1:0]    rr_q, rr_d;
   logic [CHANNELS-1:0] deb_q, deb_d;
   logic [CHANNELS-1:0] changed_q, changed_d;
   logic                busy_q, busy_d;

   logic [CHANNELS-1:0] s;
   logic [CHANNELS-1:0] req;
   logic                found;
   logic [IDX_W-1:0]    pick;
   logic [IDX_W-1:0]    next_ptr;
   int unsigned         k;

   // Input conditioning
`ifdef SYNC2_EN
   logic [CHANNELS-1:0] sync1_q, sync2_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= noisy;
         sync2_q <= sync1_q;
      end
   end

   assign s = sync2_q;
`else
   assign s = noisy;
`endif

   assign req = s ^ deb_q;

   // Pointer just past the current owner, wrapping at CHANNELS
   assign next_ptr = (grant_q == IDX_W'(CHANNELS - 1)) ? '0 : grant_q + IDX_W'(1);

   // Round-robin pick plus next-state / output logic
   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      grant_d   = grant_q;
      rr_d      = rr_q;
      deb_d     = deb_q;
      changed_d = '0;
      found     = 1'b0;
      pick      = '0;
      k         = 0;

      for (int unsigned i = 0; i < CHANNELS; i++) begin
         k = 32'(rr_q) + i;
         if (k >= CHANNELS) k = k - CHANNELS;
         if (!found && req[k]) begin
            found = 1'b1;
            pick  = IDX_W'(k);
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (found) begin
               grant_d = pick;
               timer_d = '0;
               state_d = ST_TIMING;
            end
         end
         ST_TIMING: begin
            // Bounce-back abort outranks terminal count; timer holds at terminal
            if (!req[grant_q]) begin
               rr_d    = next_ptr;
               state_d = ST_IDLE;
            end else if (timer_q == CNT_W'(SETTLE_CYCLES - 1)) begin
               state_d = ST_COMMIT;
            end else begin
               timer_d = timer_q + CNT_W'(1);
            end
         end
         ST_COMMIT: begin
            deb_d[grant_q]     = ~deb_q[grant_q];
            changed_d[grant_q] = 1'b1;
            rr_d               = next_ptr;
            state_d            = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         timer_q   <= '0;
         grant_q   <= '0;
         rr_q      <= '0;
         deb_q     <= '0;
         changed_q <= '0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         grant_q   <= grant_d;
         rr_q      <= rr_d;
         deb_q     <= deb_d;
         changed_q <= changed_d;
         busy_q    <= busy_d;
      end
   end

   assign debounced = deb_q;
   assign changed   = changed_q;
   assign busy      = busy_q;
   assign grant_idx = grant_q;

endmodule

// File: tb/tb_debounce_scheduler.sv
// -----------------------------------------------------------------------------
// tb_debounce_scheduler
//   Directed bench for debounce_scheduler (CHANNELS=4, SETTLE_CYCLES=10).
//   Stimulus pushes expected changed pulses (cycle, changed, debounced) into a
//   queue; a negedge monitor pops and compares whenever changed is non-zero,
//   and flags pulses that are unexpected or overdue.
// -----------------------------------------------------------------------------
module tb_debounce_scheduler;

   localparam int unsigned CH = 4;
   localparam int unsigned SC = 10;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [CH-1:0] noisy;
   logic [CH-1:0] debounced;
   logic [CH-1:0] changed;
   logic          busy;
   logic [1:0]    grant_idx;

   debounce_scheduler #(.CHANNELS(CH), .SETTLE_CYCLES(SC)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .noisy     (noisy),
      .debounced (debounced),
      .changed   (changed),
      .busy      (busy),
      .grant_idx (grant_idx)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int unsigned cyc;
      logic [3:0]  chg;
      logic [3:0]  deb;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        m_e;
   int unsigned n_cmp = 0;
   int unsigned n_err = 0;
   int unsigned t0    = 0;
   bit          mon_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic mark();
      t0 = cyc;
   endtask

   // Advance to #1 after the edge that starts relative cycle c
   task automatic at_cycle(input int unsigned c);
      while (cyc < t0 + c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic expect_pulse(input int unsigned c, input logic [3:0] chg, input logic [3:0] deb);
      exp_t e;
      e.cyc = t0 + c;
      e.chg = chg;
      e.deb = deb;
      exp_q.push_back(e);
   endtask

   task automatic drain(input string name);
      chk({name, "_pending"}, 32'(exp_q.size()), 32'd0);
      chk({name, "_busy"}, 32'(busy), 32'd0);
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (mon_en) begin
         if (exp_q.size() != 0 && cyc > exp_q[0].cyc) begin
            n_cmp++;
            n_err++;
            $display("FAIL missing_pulse: no pulse seen, expected changed=%b at cycle %0d (now %0d)",
                     exp_q[0].chg, exp_q[0].cyc, cyc);
            m_e = exp_q.pop_front();
         end
         if (changed !== 4'b0000) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_pulse: changed=%b debounced=%b at cycle %0d, expected no pulse",
                        changed, debounced, cyc);
            end else begin
               m_e = exp_q.pop_front();
               chk("pulse_cycle", 32'(cyc), 32'(m_e.cyc));
               chk("pulse_changed", 32'(changed), 32'(m_e.chg));
               chk("pulse_debounced", 32'(debounced), 32'(m_e.deb));
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish, expected completion before 100000 ns");
      $fatal(1);
   end

   initial begin
      // Reset held with all inputs high
      reset_n = 1'b0;
      noisy   = 4'hF;
      repeat (3) @(posedge clk);
      #1;
      mon_en = 1'b1;
      chk("rst_debounced", 32'(debounced), 32'h0);
      chk("rst_changed", 32'(changed), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_grant", 32'(grant_idx), 32'h0);
      mark();
      reset_n = 1'b1;
      at_cycle(1);
      chk("release_busy", 32'(busy), 32'h1);
      chk("release_grant", 32'(grant_idx), 32'h0);
      reset_n = 1'b0;
      noisy   = 4'h0;
      #1;
      chk("rerst_busy", 32'(busy), 32'h0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // Contention: ch0, ch1, ch3 served round-robin from pointer 0
      mark();
      noisy = 4'b1011;
      expect_pulse(12, 4'b0001, 4'b0001);
      expect_pulse(24, 4'b0010, 4'b0011);
      expect_pulse(36, 4'b1000, 4'b1011);
      at_cycle(38);
      drain("contention_press");
      mark();
      noisy = 4'b0000;
      expect_pulse(12, 4'b0001, 4'b1010);
      expect_pulse(24, 4'b0010, 4'b1000);
      expect_pulse(36, 4'b1000, 4'b0000);
      at_cycle(38);
      drain("contention_release");

      // Clean press on ch1
      mark();
      noisy = 4'b0010;
      expect_pulse(12, 4'b0010, 4'b0010);
      chk("press_busy_c0", 32'(busy), 32'h0);
      at_cycle(1);
      chk("press_busy_c1", 32'(busy), 32'h1);
      chk("press_grant", 32'(grant_idx), 32'h1);
      at_cycle(11);
      chk("press_busy_c11", 32'(busy), 32'h1);
      at_cycle(12);
      chk("press_busy_c12", 32'(busy), 32'h0);
      at_cycle(14);
      drain("press");
      mark();
      noisy = 4'b0000;
      expect_pulse(12, 4'b0010, 4'b0000);
      at_cycle(14);
      drain("press_release");

      // Bounce on ch2: abort, pointer moves to 3
      mark();
      noisy = 4'b0100;
      at_cycle(6);
      noisy = 4'b0000;
      chk("bounce_busy_c6", 32'(busy), 32'h1);
      at_cycle(7);
      chk("bounce_busy_c7", 32'(busy), 32'h0);
      at_cycle(20);
      chk("bounce_debounced", 32'(debounced), 32'h0);
      drain("bounce");
      // ch2 and ch3 together: pointer 3 serves ch3 first
      mark();
      noisy = 4'b1100;
      expect_pulse(12, 4'b1000, 4'b1000);
      expect_pulse(24, 4'b0100, 4'b1100);
      at_cycle(26);
      drain("rr_after_bounce");
      mark();
      noisy = 4'b0000;
      expect_pulse(12, 4'b1000, 4'b0100);
      expect_pulse(24, 4'b0100, 4'b0000);
      at_cycle(26);
      drain("rr_release");

      // Terminal-count race on ch0: drop input while timer==9
      mark();
      noisy = 4'b0001;
      at_cycle(1);
      chk("race_grant", 32'(grant_idx), 32'h0);
      at_cycle(10);
      noisy = 4'b0000;
      at_cycle(11);
      chk("race_busy_c11", 32'(busy), 32'h0);
      at_cycle(20);
      chk("race_debounced", 32'(debounced), 32'h0);
      drain("race");

      // Async reset mid-TIMING with a committed level present
      mark();
      noisy = 4'b1000;
      expect_pulse(12, 4'b1000, 4'b1000);
      at_cycle(14);
      drain("pre_reset");
      mark();
      noisy = 4'b1010;
      at_cycle(1);
      chk("midrst_grant", 32'(grant_idx), 32'h1);
      at_cycle(6);
      chk("midrst_busy_before", 32'(busy), 32'h1);
      reset_n = 1'b0;
      #1;
      chk("midrst_busy", 32'(busy), 32'h0);
      chk("midrst_debounced", 32'(debounced), 32'h0);
      chk("midrst_changed", 32'(changed), 32'h0);
      chk("midrst_grant0", 32'(grant_idx), 32'h0);
      @(posedge clk);
      #1;
      mark();
      reset_n = 1'b1;
      expect_pulse(12, 4'b0010, 4'b0010);
      expect_pulse(24, 4'b1000, 4'b1010);
      at_cycle(1);
      chk("postrst_busy", 32'(busy), 32'h1);
      chk("postrst_grant", 32'(grant_idx), 32'h1);
      at_cycle(26);
      drain("post_reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
